// File: rtl/systolic_edge_feeder_if.sv
// rtl/systolic_edge_feeder_if.sv - K-slice beat stream from operand buffers into the edge feeder
interface systolic_edge_feeder_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] a_vec;
    logic [N*DATA_W-1:0] b_vec;

    modport master (output in_valid, output a_vec, output b_vec, input in_ready);
    modport slave  (input in_valid, input a_vec, input b_vec, output in_ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// rtl/systolic_edge_feeder.sv - diagonal-skew west/north edge driver for an NxN PE array
// Optional FEEDER_PERF_EN adds the stall_cnt port counting STREAM cycles without a beat.
module systolic_edge_feeder #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int N      = 4,
    parameter int K      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [N*ACC_W-1:0]  c_vec,
    systolic_edge_feeder_if.slave beat,
    output logic [N*DATA_W-1:0] acc_data,
    output logic [N-1:0]        acc_data_valid,
    output logic [N*DATA_W-1:0] wet_data,
    output logic [N-1:0]        wet_data_valid,
    output logic [N-1:0]        counter_sync,
    output logic [N*ACC_W-1:0]  C_data,
    output logic [N-1:0]        C_data_valid,
    output logic [N-1:0]        c_lock,
    output logic                busy,
`ifdef FEEDER_PERF_EN
    output logic                done,
    output logic [31:0]         stall_cnt
`else
    output logic                done
`endif
);
    localparam int BW = $clog2(K + 1);
    localparam int DW = $clog2(N + 2);
    localparam logic [BW-1:0] LAST_BEAT = BW'(K - 1);
    localparam logic [DW-1:0] DRAIN_END = DW'(N + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    state_t             state;
    logic               ready_q;
    logic               accept;
    logic [BW-1:0]      beat_cnt;
    logic [DW-1:0]      drain_cnt;
    logic [N*ACC_W-1:0] c_lat;

    assign beat.in_ready = ready_q;
    assign accept        = beat.in_valid && ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            c_lat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= STREAM;
                        ready_q  <= 1'b1;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        c_lat    <= c_vec;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state     <= DRAIN;
                            ready_q   <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Hold off done until the last row lane has dropped counter_sync.
                    if (drain_cnt == DRAIN_END) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEEDER_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == STREAM && !beat.in_valid && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    // Stage 0 captures the accepted beat; index d of each flag chain is d registers later.
    logic [N*DATA_W-1:0] s0_a;
    logic [N*DATA_W-1:0] s0_b;
    logic [N:0]          gv;
    logic [N:0]          gl;
    logic [N-1:0]        gf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_a <= '0;
            s0_b <= '0;
            gv   <= '0;
            gl   <= '0;
            gf   <= '0;
        end else begin
            if (accept) begin
                s0_a <= beat.a_vec;
                s0_b <= beat.b_vec;
            end
            gv[0]   <= accept;
            gl[0]   <= accept && (beat_cnt == LAST_BEAT);
            gf[0]   <= accept && (beat_cnt == '0);
            gv[N:1] <= gv[N-1:0];
            gl[N:1] <= gl[N-1:0];
            for (int d = 1; d < N; d++) begin
                gf[d] <= gf[d-1];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] ra [1:i+1];
        logic [DATA_W-1:0] rb [1:i+1];
        logic              cs_r;
        logic              cv_r;
        logic [ACC_W-1:0]  cd_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int j = 1; j <= i + 1; j++) begin
                    ra[j] <= '0;
                    rb[j] <= '0;
                end
                cs_r <= 1'b0;
                cv_r <= 1'b0;
                cd_r <= '0;
            end else begin
                ra[1] <= s0_a[i*DATA_W +: DATA_W];
                rb[1] <= s0_b[i*DATA_W +: DATA_W];
                for (int j = 2; j <= i + 1; j++) begin
                    ra[j] <= ra[j-1];
                    rb[j] <= rb[j-1];
                end
                // First beat about to reach the output raises sync; last beat leaving drops it.
                if (gf[i])
                    cs_r <= 1'b1;
                else if (gl[i+1])
                    cs_r <= 1'b0;
                cv_r <= gf[i];
                if (gf[i])
                    cd_r <= c_lat[i*ACC_W +: ACC_W];
            end
        end

        assign acc_data[i*DATA_W +: DATA_W] = ra[i+1];
        assign wet_data[i*DATA_W +: DATA_W] = rb[i+1];
        assign acc_data_valid[i]            = gv[i+1];
        assign wet_data_valid[i]            = gv[i+1];
        assign counter_sync[i]              = cs_r;
        assign C_data[i*ACC_W +: ACC_W]     = cd_r;
        assign C_data_valid[i]              = cv_r;
        assign c_lock[i]                    = cv_r;
    end
endmodule
